// File: rtl/bram_stream_reader_if.sv
// Bus bundle for bram_stream_reader: transfer control, BRAM read port and AXI-Stream master.
// master = the reader, slave = whatever drives start/BRAM data/ready.
interface bram_stream_reader_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int BIT_WIDTH  = 32,
  parameter int LEN_WIDTH  = 12
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [LEN_WIDTH-1:0]  length;
  logic                  busy;
  logic                  done;
  logic                  bram_re;
  logic [ADDR_WIDTH-1:0] bram_raddr;
  logic [BIT_WIDTH-1:0]  bram_rdo;
  logic                  m_tvalid;
  logic                  m_tready;
  logic [BIT_WIDTH-1:0]  m_tdata;
  logic                  m_tlast;

  modport master (
    input  start, base_addr, length, bram_rdo, m_tready,
    output busy, done, bram_re, bram_raddr, m_tvalid, m_tdata, m_tlast
  );

  modport slave (
    output start, base_addr, length, bram_rdo, m_tready,
    input  busy, done, bram_re, bram_raddr, m_tvalid, m_tdata, m_tlast
  );
endinterface

// File: rtl/bram_stream_reader.sv
// Streams `length` consecutive BRAM words onto AXI-Stream through a 2-entry skid buffer.
// Define BRAM_READER_TLAST_EN to drive m_tlast on the final beat; otherwise m_tlast is tied low.
//
// state   | meaning
// IDLE    | waiting for start; zero-length start only pulses done
// READ    | issuing reads while buffer + in-flight leaves room
// DRAIN   | all reads issued, emptying buffer until final beat accepted
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 12,
  parameter int BIT_WIDTH  = 32,
  parameter int LEN_WIDTH  = 12
) (
  input logic                  clk,
  input logic                  rst_n,
  bram_stream_reader_if.master bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_rd_left;
  logic [LEN_WIDTH-1:0]  r_beat_left;
  logic                  r_inflight;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic                  r_done;
  logic [1:0]            r_cnt;
  logic [BIT_WIDTH-1:0]  r_buf [2];

  logic                  w_valid;
  logic                  w_pop;
  logic                  w_re;
  logic                  w_accept;
  logic                  w_zero_start;
  logic                  w_last_beat;
  logic [2:0]            w_occ;

  assign w_valid      = (r_cnt != 2'd0);
  assign w_pop        = w_valid & bus.m_tready;
  // A beat leaving this cycle frees its slot for the read issued now.
  assign w_occ        = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_re         = (r_state == S_READ) && (w_occ < 3'd2);
  assign w_accept     = (r_state == S_IDLE) && bus.start && (bus.length != '0);
  assign w_zero_start = (r_state == S_IDLE) && bus.start && (bus.length == '0);
  assign w_last_beat  = w_pop && (r_beat_left == LEN_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_READ;
      S_READ:  if (w_re && (r_rd_left == LEN_WIDTH'(1))) w_next = S_DRAIN;
      S_DRAIN: if (w_last_beat) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_rd_left   <= '0;
      r_beat_left <= '0;
      r_inflight  <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_done      <= 1'b0;
      r_cnt       <= 2'd0;
      r_buf[0]    <= '0;
      r_buf[1]    <= '0;
    end else begin
      r_done     <= w_zero_start || ((r_state == S_DRAIN) && w_last_beat);
      r_inflight <= w_re;
      if (w_accept) begin
        r_addr      <= bus.base_addr;
        r_rd_left   <= bus.length;
        r_beat_left <= bus.length;
      end else begin
        if (w_re) begin
          r_addr    <= r_addr + ADDR_WIDTH'(1);
          r_rd_left <= r_rd_left - LEN_WIDTH'(1);
        end
        if (w_pop) r_beat_left <= r_beat_left - LEN_WIDTH'(1);
      end
      if (r_inflight) begin
        r_buf[r_wr_ptr] <= bus.bram_rdo;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  always_comb begin
    bus.busy       = (r_state != S_IDLE);
    bus.done       = r_done;
    bus.bram_re    = w_re;
    bus.bram_raddr = r_addr;
    bus.m_tvalid   = w_valid;
    bus.m_tdata    = w_valid ? r_buf[r_rd_ptr] : '0;
`ifdef BRAM_READER_TLAST_EN
    bus.m_tlast    = w_valid && (r_beat_left == LEN_WIDTH'(1));
`else
    bus.m_tlast    = 1'b0;
`endif
  end
endmodule
